// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared constants and types for the FM extender
package proj_pkg;

  localparam int FM_DATA_BITS              = 2;
  localparam int FM_EXTENDER_FRAG_LEN_BITS = 16;
  localparam int SIGNED_INDICE_LEN         = 8;
  localparam int FM_EXT_SHIFT              = 2;
  localparam int FM_EXT_MAX_MISMATCH       = 1;

  localparam int FRAG_SYMS  = FM_EXTENDER_FRAG_LEN_BITS / FM_DATA_BITS;
  localparam int SCORE_BITS = $clog2(FRAG_SYMS + 1);

  typedef enum logic [2:0] {SWAP, IDLE, SCAN, DRAIN, RESULT} ext_state_t;

  typedef logic [SCORE_BITS-1:0] score_t;

endpackage

// File: rtl/proj_fm_mismatch_cnt.sv
// rtl/proj_fm_mismatch_cnt.sv - counts differing symbols between two fragments
module proj_fm_mismatch_cnt
  import proj_pkg::*;
#(
  parameter int DATA_BITS = FM_DATA_BITS,
  parameter int FRAG_LEN  = FM_EXTENDER_FRAG_LEN_BITS
) (
  input  logic [FRAG_LEN-1:0] frag_a,
  input  logic [FRAG_LEN-1:0] frag_b,
  output score_t              score
);

  localparam int N_SYMS = FRAG_LEN / DATA_BITS;

  always_comb begin
    score = '0;
    for (int i = 0; i < N_SYMS; i++) begin
      if (frag_a[i*DATA_BITS +: DATA_BITS] != frag_b[i*DATA_BITS +: DATA_BITS])
        score = score + score_t'(1);
    end
  end

endmodule

// File: rtl/proj_fm_extender.sv
// rtl/proj_fm_extender.sv - sweeps the FM read window around a seed hit and reports the best shift
module proj_fm_extender
  import proj_pkg::*;
#(
  parameter int DATA_BITS         = proj_pkg::FM_DATA_BITS,
  parameter int FRAG_LEN          = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
  parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
  parameter int SHIFT             = proj_pkg::FM_EXT_SHIFT,
  parameter int MAX_MISMATCH      = proj_pkg::FM_EXT_MAX_MISMATCH
) (
  input  logic                                          in_clk,
  input  logic                                          in_rst,
  input  logic                                          hit_valid,
  output logic                                          hit_ready,
  input  logic signed [SIGNED_INDICE_LEN-1:0]           hit_pos,
  input  logic [FRAG_LEN-1:0]                           hit_query,
  input  logic                                          hit_last,
  input  logic                                          fm_wait,
  output logic                                          fm_chg_idx,
  output logic signed [SIGNED_INDICE_LEN-1:0]           fm_frag_idx,
  input  logic [FRAG_LEN-1:0]                           fm_rdata,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic signed [SIGNED_INDICE_LEN-1:0]           res_pos,
  output logic [$clog2(FRAG_LEN/DATA_BITS+1)-1:0]       res_score,
  output logic                                          res_found
);

  localparam int N_SYMS = FRAG_LEN / DATA_BITS;
  localparam int IW     = SIGNED_INDICE_LEN;

  typedef logic signed [IW-1:0] idx_t;

  localparam idx_t K_END = idx_t'(SHIFT + 1);

  ext_state_t          state, state_nxt;
  idx_t                pos_q, k_q, cap_idx, best_pos, nxt_pos;
  idx_t                base, koff, issue_idx;
  logic signed [IW:0]  sum;
  logic [FRAG_LEN-1:0] query_q, cap_data;
  logic                last_q, cap_valid;
  score_t              best_score, cur_score, nxt_score;

  proj_fm_mismatch_cnt #(
    .DATA_BITS (DATA_BITS),
    .FRAG_LEN  (FRAG_LEN)
  ) u_mismatch_cnt (
    .frag_a (cap_data),
    .frag_b (query_q),
    .score  (cur_score)
  );

  // The first offset is issued from the hit port directly, so SCAN starts with a valid index.
  always_comb begin
    base = (state == IDLE) ? hit_pos : pos_q;
    koff = (state == IDLE) ? idx_t'(-SHIFT) : k_q;
    sum  = {base[IW-1], base} + {koff[IW-1], koff};
    if (sum[IW] != sum[IW-1])
      issue_idx = sum[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    else
      issue_idx = sum[IW-1:0];
  end

  always_comb begin
    nxt_score = best_score;
    nxt_pos   = best_pos;
    if (cap_valid && (cur_score < best_score)) begin
      nxt_score = cur_score;
      nxt_pos   = cap_idx;
    end
  end

  always_comb begin
    state_nxt  = state;
    hit_ready  = 1'b0;
    fm_chg_idx = 1'b0;
    case (state)
      SWAP: begin
        if (fm_wait) begin
          fm_chg_idx = !in_rst;
          state_nxt  = IDLE;
        end
      end
      IDLE: begin
        hit_ready = 1'b1;
        if (hit_valid) state_nxt = SCAN;
      end
      SCAN:   if (k_q == K_END) state_nxt = DRAIN;
      DRAIN:  state_nxt = RESULT;
      RESULT: if (res_ready) state_nxt = last_q ? SWAP : IDLE;
      default: state_nxt = SWAP;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state       <= SWAP;
      pos_q       <= '0;
      k_q         <= '0;
      query_q     <= '0;
      last_q      <= 1'b0;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      cap_idx     <= '0;
      best_score  <= score_t'(N_SYMS);
      best_pos    <= '0;
      fm_frag_idx <= '0;
      res_valid   <= 1'b0;
      res_pos     <= '0;
      res_score   <= '0;
      res_found   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cap_valid <= (state == SCAN);
      if (state == SCAN) begin
        cap_data <= fm_rdata;
        cap_idx  <= fm_frag_idx;
      end
      if (cap_valid) begin
        best_score <= nxt_score;
        best_pos   <= nxt_pos;
      end
      case (state)
        IDLE: begin
          if (hit_valid) begin
            pos_q       <= hit_pos;
            query_q     <= hit_query;
            last_q      <= hit_last;
            k_q         <= idx_t'(1 - SHIFT);
            fm_frag_idx <= issue_idx;
            best_score  <= score_t'(N_SYMS);
            best_pos    <= '0;
          end
        end
        SCAN: begin
          if (k_q != K_END) begin
            fm_frag_idx <= issue_idx;
            k_q         <= k_q + idx_t'(1);
          end
        end
        DRAIN: begin
          res_valid <= 1'b1;
          res_pos   <= nxt_pos;
          res_score <= nxt_score;
          res_found <= (nxt_score <= score_t'(MAX_MISMATCH));
        end
        RESULT: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
